sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Single-clock, parametrised FIFO: successor to the dual-clock FIFO for same-domain buffering.
//  Adds an occupancy count, programmable almost-full/almost-empty thresholds,
//  sticky over/underflow status and an optional first-word-fall-through (FWFT) mode.
//  Sits between producer and consumer logic sharing one clock; storage is an inferred RAM.
// PARAMETERS
//  DATA_WIDTH  8           word width in bits
//  DEPTH       256         number of entries; power of 2, >=4 (elaboration error otherwise)
//  FWFT        0           0 = registered read (1-cycle latency), 1 = head word shown on data_out
//  AF_THRESH   DEPTH-4     almost_full asserts when level >= AF_THRESH
//  AE_THRESH   4           almost_empty asserts when level <= AE_THRESH
//  Legal: 0 <= AE_THRESH < AF_THRESH <= DEPTH; else elaboration error. ADDR_W = $clog2(DEPTH).
// PORTS
//  clk           in   1             single clock, all logic on rising edge
//  rst_n         in   1             asynchronous, active-low reset
//  w_en          in   1             write request
//  data_in       in   DATA_WIDTH    write data
//  r_en          in   1             read request
//  data_out      out  DATA_WIDTH    read data
//  full/empty    out  1 each        level==DEPTH / level==0
//  half_full     out  1             level >= DEPTH/2
//  half_empty    out  1             level <  DEPTH/2
//  almost_full   out  1             level >= AF_THRESH
//  almost_empty  out  1             level <= AE_THRESH
//  write_error   out  1             1-cycle pulse: w_en while full
//  read_error    out  1             1-cycle pulse: r_en while empty
//  err_clr       in   1             clears ovf_sticky/unf_sticky
//  ovf_sticky    out  1             set by any write_error, held until err_clr
//  unf_sticky    out  1             set by any read_error, held until err_clr
//  level         out  ADDR_W+1      current occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset (async assert, sync release): wptr=rptr=0, level=0; empty, half_empty, almost_empty = 1;
//    full, half_full, almost_full, errors, stickies = 0; data_out = 0. RAM contents not reset.
//  - Write accepted iff w_en && !full; read accepted iff r_en && !empty. Flags are the registered
//    values of the current cycle; no bypass: full blocks writes even with r_en, empty blocks reads even with w_en.
//  - Both accepted in one cycle: level unchanged, both pointers advance, order preserved.
//  - Pointers are ADDR_W bits, wrap modulo DEPTH; level is a separate up/down counter.
//  - All flags and level are registered, computed from next-state level: update on the same edge as the access.
//  - FWFT=0: data_out <= mem[rptr] on an accepted read (valid after that edge); holds otherwise.
//  - FWFT=1: data_out = mem[rptr] whenever !empty (write at edge N -> empty=0, data_out valid after N);
//    r_en pops the head; data_out holds its last value when empty.
//  - write_error/read_error: registered, high exactly one cycle after a rejected request; repeated
//    rejected requests give back-to-back pulses. Rejected accesses change no state.
//  - Stickies: set on the error edge; err_clr clears them; a set and a clear in the same cycle -> set wins.
//  - Reset mid-operation discards all contents; any in-flight request that cycle is ignored.
// TESTING
//  1 Reset: release rst_n -> empty=1, almost_empty=1, half_empty=1, full=0, level=0, data_out=0.
//  2 Fill (DEPTH=256): write 0..255 -> almost_empty drops at level 5, half_full at 128,
//    almost_full at 252, full at 256. 257th write -> write_error pulse 1 cycle, ovf_sticky=1, level=256.
//  3 Drain (FWFT=0): 256 reads -> data_out 0..255, each one cycle after its read; 257th read ->
//    read_error pulse, unf_sticky=1, data_out holds 255.
//  4 Simultaneous: hold level 10, w_en&r_en for 600 cycles -> level stays 10, data order intact
//    across pointer wrap.
//  5 FWFT=1: write 0xA5 into empty -> after that edge empty=0, data_out=0xA5; r_en -> empty=1 next edge.
//  6 Reset at level 100 -> reset values at once; then write/read 0x3C returns 0x3C; err_clr clears stickies.

Source files
------------

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: handshake/status bundle between a FIFO and the logic using it.
//   master: drives w_en, data_in, r_en, err_clr; observes data, flags, errors, level
//   slave : the FIFO side (inverse directions)
interface sync_fifo_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256
);
    localparam int ADDR_W = $clog2(DEPTH);
    logic                  w_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  half_full;
    logic                  half_empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  write_error;
    logic                  read_error;
    logic                  err_clr;
    logic                  ovf_sticky;
    logic                  unf_sticky;
    logic [ADDR_W:0]       level;
    modport master (
        output w_en, data_in, r_en, err_clr,
        input  data_out, full, empty, half_full, half_empty, almost_full, almost_empty,
               write_error, read_error, ovf_sticky, unf_sticky, level
    );
    modport slave (
        input  w_en, data_in, r_en, err_clr,
        output data_out, full, empty, half_full, half_empty, almost_full, almost_empty,
               write_error, read_error, ovf_sticky, unf_sticky, level
    );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy count, thresholds, sticky errors, optional FWFT.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sync_fifo_param_if.slave (write/read requests, data, status flags, level)
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = DEPTH - 4,
    parameter int AE_THRESH  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    sync_fifo_param_if.slave   bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LW     = ADDR_W + 1;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of 2 and >= 4");
    end
    if (AE_THRESH < 0 || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH) begin : g_bad_thresh
        $error("sync_fifo_param: need 0 <= AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wptr, rptr;
    logic [ADDR_W:0]       level_q, level_d;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  full_q, empty_q, hf_q, he_q, af_q, ae_q;
    logic                  werr_q, rerr_q, ovf_q, unf_q;

    // Acceptance uses only the registered flags: no bypass between read and write.
    always_comb begin
        wr_acc  = bus.w_en && !full_q;
        rd_acc  = bus.r_en && !empty_q;
        level_d = level_q + LW'(wr_acc) - LW'(rd_acc);
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wptr] <= bus.data_in;
    end

    // Flags are derived from the next level so they move on the same edge as the access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            level_q <= '0;
            rd_q    <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            hf_q    <= 1'b0;
            he_q    <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            werr_q  <= 1'b0;
            rerr_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (wr_acc) wptr <= wptr + ADDR_W'(1);
            if (rd_acc) begin
                rptr <= rptr + ADDR_W'(1);
                rd_q <= mem[rptr];
            end
            level_q <= level_d;
            full_q  <= level_d == LW'(DEPTH);
            empty_q <= level_d == '0;
            hf_q    <= level_d >= LW'(DEPTH / 2);
            he_q    <= level_d <  LW'(DEPTH / 2);
            af_q    <= level_d >= LW'(AF_THRESH);
            ae_q    <= level_d <= LW'(AE_THRESH);
            werr_q  <= bus.w_en && full_q;
            rerr_q  <= bus.r_en && empty_q;
            // A new error in the same cycle as err_clr keeps the sticky set.
            ovf_q   <= (bus.w_en && full_q) || (ovf_q && !bus.err_clr);
            unf_q   <= (bus.r_en && empty_q) || (unf_q && !bus.err_clr);
        end
    end

    // In FWFT mode the head word is shown live; rd_q keeps the last popped word for when empty.
    assign bus.data_out     = (FWFT != 0 && !empty_q) ? mem[rptr] : rd_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.half_full    = hf_q;
    assign bus.half_empty   = he_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.write_error  = werr_q;
    assign bus.read_error   = rerr_q;
    assign bus.ovf_sticky   = ovf_q;
    assign bus.unf_sticky   = unf_q;
    assign bus.level        = level_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed self-checking bench for sync_fifo_param (FWFT=0 depth 256, FWFT=1 depth 4).
module tb_sync_fifo_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_WIDTH(8), .DEPTH(256)) f1 ();
    sync_fifo_param_if #(.DATA_WIDTH(8), .DEPTH(4))   f2 ();

    sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(256), .FWFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(f1)
    );
    sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(1), .AF_THRESH(3), .AE_THRESH(1)) dut_fwft (
        .clk(clk), .rst_n(rst_n), .bus(f2)
    );

    int compared = 0;
    int mismatched = 0;

    // {empty, almost_empty, half_empty, full, half_full, almost_full}
    logic [5:0] flags1, flags2;
    assign flags1 = {f1.empty, f1.almost_empty, f1.half_empty, f1.full, f1.half_full, f1.almost_full};
    assign flags2 = {f2.empty, f2.almost_empty, f2.half_empty, f2.full, f2.half_full, f2.almost_full};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) tick;
        rst_n = 1'b1;
        tick;
        compared++;
        if (flags1 !== 6'b111000) begin mismatched++; $display("FAIL reset_flags got %b want 111000", flags1); end
        compared++;
        if (f1.level !== 9'd0) begin mismatched++; $display("FAIL reset_level got %0d want 0", f1.level); end
        compared++;
        if (f1.data_out !== 8'h00) begin mismatched++; $display("FAIL reset_data got %h want 00", f1.data_out); end
        compared++;
        if ({f1.write_error, f1.read_error, f1.ovf_sticky, f1.unf_sticky} !== 4'b0000) begin
            mismatched++; $display("FAIL reset_errors got %b want 0000",
                                   {f1.write_error, f1.read_error, f1.ovf_sticky, f1.unf_sticky});
        end
        compared++;
        if (flags2 !== 6'b111000 || f2.data_out !== 8'h00) begin
            mismatched++; $display("FAIL reset_fwft got flags %b data %h want 111000 00", flags2, f2.data_out);
        end
    endtask

    task automatic test_fill;
        logic [5:0] exp;
        for (int i = 0; i < 256; i++) begin
            f1.w_en = 1'b1;
            f1.data_in = 8'(i);
            tick;
            exp = {1'b0, (i + 1) <= 4, (i + 1) < 128, (i + 1) == 256, (i + 1) >= 128, (i + 1) >= 252};
            compared++;
            if (flags1 !== exp) begin mismatched++; $display("FAIL fill_flags[%0d] got %b want %b", i + 1, flags1, exp); end
            compared++;
            if (f1.level !== 9'(i + 1)) begin mismatched++; $display("FAIL fill_level got %0d want %0d", f1.level, i + 1); end
        end
        f1.data_in = 8'hEE;
        tick;
        compared++;
        if ({f1.write_error, f1.ovf_sticky, f1.full} !== 3'b111 || f1.level !== 9'd256) begin
            mismatched++; $display("FAIL overflow got werr/ovf/full %b level %0d want 111 256",
                                   {f1.write_error, f1.ovf_sticky, f1.full}, f1.level);
        end
        f1.w_en = 1'b0;
        tick;
        compared++;
        if ({f1.write_error, f1.ovf_sticky} !== 2'b01) begin
            mismatched++; $display("FAIL overflow_pulse got werr/ovf %b want 01", {f1.write_error, f1.ovf_sticky});
        end
    endtask

    task automatic test_drain;
        logic [5:0] exp;
        for (int i = 0; i < 256; i++) begin
            f1.r_en = 1'b1;
            tick;
            compared++;
            if (f1.data_out !== 8'(i)) begin mismatched++; $display("FAIL drain_data got %h want %h", f1.data_out, 8'(i)); end
            exp = {(255 - i) == 0, (255 - i) <= 4, (255 - i) < 128, 1'b0, (255 - i) >= 128, (255 - i) >= 252};
            compared++;
            if (flags1 !== exp || f1.level !== 9'(255 - i)) begin
                mismatched++; $display("FAIL drain_state got %b/%0d want %b/%0d", flags1, f1.level, exp, 255 - i);
            end
        end
        tick;
        compared++;
        if ({f1.read_error, f1.unf_sticky} !== 2'b11 || f1.data_out !== 8'hFF || f1.level !== 9'd0) begin
            mismatched++; $display("FAIL underflow got rerr/unf %b data %h level %0d want 11 ff 0",
                                   {f1.read_error, f1.unf_sticky}, f1.data_out, f1.level);
        end
        f1.err_clr = 1'b1;
        tick;
        compared++;
        if ({f1.read_error, f1.unf_sticky, f1.ovf_sticky} !== 3'b110) begin
            mismatched++; $display("FAIL set_wins got rerr/unf/ovf %b want 110",
                                   {f1.read_error, f1.unf_sticky, f1.ovf_sticky});
        end
        f1.err_clr = 1'b0;
        f1.r_en = 1'b0;
        tick;
        compared++;
        if ({f1.read_error, f1.unf_sticky} !== 2'b01) begin
            mismatched++; $display("FAIL underflow_pulse got rerr/unf %b want 01", {f1.read_error, f1.unf_sticky});
        end
    endtask

    task automatic test_simultaneous;
        logic [7:0] wv = 8'd0;
        logic [7:0] rv = 8'd0;
        f1.w_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            f1.data_in = wv;
            wv++;
            tick;
        end
        f1.r_en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            f1.data_in = wv;
            wv++;
            tick;
            compared++;
            if (f1.data_out !== rv) begin mismatched++; $display("FAIL simul_data[%0d] got %h want %h", i, f1.data_out, rv); end
            rv++;
            compared++;
            if (f1.level !== 9'd10) begin mismatched++; $display("FAIL simul_level[%0d] got %0d want 10", i, f1.level); end
        end
        f1.w_en = 1'b0;
        f1.r_en = 1'b0;
        tick;
    endtask

    task automatic test_fwft;
        f2.w_en = 1'b1;
        f2.data_in = 8'hA5;
        tick;
        f2.w_en = 1'b0;
        compared++;
        if (f2.empty !== 1'b0 || f2.data_out !== 8'hA5) begin
            mismatched++; $display("FAIL fwft_show got empty %b data %h want 0 a5", f2.empty, f2.data_out);
        end
        f2.r_en = 1'b1;
        tick;
        f2.r_en = 1'b0;
        compared++;
        if (f2.empty !== 1'b1 || f2.data_out !== 8'hA5 || f2.level !== 3'd0) begin
            mismatched++; $display("FAIL fwft_pop got empty %b data %h level %0d want 1 a5 0", f2.empty, f2.data_out, f2.level);
        end
        f2.w_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            f2.data_in = 8'(i * 8'h11);
            tick;
            compared++;
            if (f2.data_out !== 8'h11) begin mismatched++; $display("FAIL fwft_head got %h want 11", f2.data_out); end
        end
        compared++;
        if (flags2 !== 6'b000111) begin mismatched++; $display("FAIL fwft_full got %b want 000111", flags2); end
        f2.r_en = 1'b1;
        f2.data_in = 8'h55;
        tick;
        f2.w_en = 1'b0;
        compared++;
        if (f2.write_error !== 1'b1 || f2.level !== 3'd3 || f2.data_out !== 8'h22 || f2.full !== 1'b0) begin
            mismatched++; $display("FAIL full_no_bypass got werr %b level %0d data %h full %b want 1 3 22 0",
                                   f2.write_error, f2.level, f2.data_out, f2.full);
        end
        tick;
        compared++;
        if (f2.data_out !== 8'h33) begin mismatched++; $display("FAIL fwft_next got %h want 33", f2.data_out); end
        tick;
        tick;
        compared++;
        if (f2.empty !== 1'b1 || f2.data_out !== 8'h44) begin
            mismatched++; $display("FAIL fwft_hold got empty %b data %h want 1 44", f2.empty, f2.data_out);
        end
        f2.w_en = 1'b1;
        f2.data_in = 8'h66;
        tick;
        f2.w_en = 1'b0;
        compared++;
        if (f2.read_error !== 1'b1 || f2.level !== 3'd1 || f2.data_out !== 8'h66) begin
            mismatched++; $display("FAIL empty_no_bypass got rerr %b level %0d data %h want 1 1 66",
                                   f2.read_error, f2.level, f2.data_out);
        end
        tick;
        f2.r_en = 1'b0;
        compared++;
        if (f2.empty !== 1'b1 || f2.data_out !== 8'h66) begin
            mismatched++; $display("FAIL fwft_last got empty %b data %h want 1 66", f2.empty, f2.data_out);
        end
    endtask

    task automatic test_reset_mid;
        f1.w_en = 1'b1;
        for (int i = 0; i < 90; i++) begin
            f1.data_in = 8'(i);
            tick;
        end
        compared++;
        if (f1.level !== 9'd100) begin mismatched++; $display("FAIL pre_reset_level got %0d want 100", f1.level); end
        f1.r_en = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (flags1 !== 6'b111000 || f1.level !== 9'd0 || f1.data_out !== 8'h00) begin
            mismatched++; $display("FAIL async_reset got %b/%0d/%h want 111000/0/00", flags1, f1.level, f1.data_out);
        end
        compared++;
        if ({f1.ovf_sticky, f1.unf_sticky} !== 2'b00) begin
            mismatched++; $display("FAIL async_reset_sticky got %b want 00", {f1.ovf_sticky, f1.unf_sticky});
        end
        tick;
        rst_n = 1'b1;
        f1.w_en = 1'b0;
        f1.r_en = 1'b0;
        tick;
        compared++;
        if (f1.level !== 9'd0 || f1.empty !== 1'b1) begin
            mismatched++; $display("FAIL reset_ignore got level %0d empty %b want 0 1", f1.level, f1.empty);
        end
        f1.w_en = 1'b1;
        f1.data_in = 8'h3C;
        tick;
        f1.w_en = 1'b0;
        f1.r_en = 1'b1;
        tick;
        compared++;
        if (f1.data_out !== 8'h3C || f1.level !== 9'd0) begin
            mismatched++; $display("FAIL post_reset_data got %h/%0d want 3c/0", f1.data_out, f1.level);
        end
        tick;
        f1.r_en = 1'b0;
        compared++;
        if (f1.unf_sticky !== 1'b1) begin mismatched++; $display("FAIL post_reset_unf got %b want 1", f1.unf_sticky); end
        f1.err_clr = 1'b1;
        tick;
        f1.err_clr = 1'b0;
        compared++;
        if ({f1.unf_sticky, f1.read_error} !== 2'b00) begin
            mismatched++; $display("FAIL err_clr got unf/rerr %b want 00", {f1.unf_sticky, f1.read_error});
        end
    endtask

    initial begin
        f1.w_en = 1'b0; f1.r_en = 1'b0; f1.err_clr = 1'b0; f1.data_in = '0;
        f2.w_en = 1'b0; f2.r_en = 1'b0; f2.err_clr = 1'b0; f2.data_in = '0;
        test_reset;
        test_fill;
        test_drain;
        test_simultaneous;
        test_fwft;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
